// File: rtl/depth_line_buffer_if.sv
// depth_line_buffer_if: engine write port and streamed read port of the depth line buffer
interface depth_line_buffer_if #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH_W = 10
);
    logic               wr_we;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DEPTH_W-1:0] wr_depth;
    logic               wr_line_done;
    logic               wr_ready;
    logic [DEPTH_W-1:0] rd_depth;
    logic               rd_valid;
    logic               rd_ready;
    logic [ADDR_W-1:0]  rd_x;
    logic               rd_sol;
    logic               rd_eol;
    logic               rd_sof;
    logic [1:0]         lines_buffered;
    logic               overflow_err;
    modport master (
        output wr_we, wr_addr, wr_depth, wr_line_done, rd_ready,
        input  wr_ready, rd_depth, rd_valid, rd_x, rd_sol, rd_eol, rd_sof, lines_buffered, overflow_err
    );
    modport slave (
        input  wr_we, wr_addr, wr_depth, wr_line_done, rd_ready,
        output wr_ready, rd_depth, rd_valid, rd_x, rd_sol, rd_eol, rd_sof, lines_buffered, overflow_err
    );
endinterface

// File: rtl/depth_line_buffer.sv
// depth_line_buffer: ping-pong line store, random-order depth writes in, x-ordered stream out
module depth_line_buffer #(
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int DEPTH_W = 10,
    parameter int ADDR_W  = $clog2(X_SIZE)
) (
    input logic                clk,
    input logic                reset,
    depth_line_buffer_if.slave bus
);
    localparam int LINE_W = Y_SIZE > 1 ? $clog2(Y_SIZE) : 1;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_t;
    rd_state_t          state;
    logic [DEPTH_W-1:0] mem [2][X_SIZE];
    logic [DEPTH_W-1:0] ram_q;
    logic [1:0]         full_cnt;
    logic               wb;
    logic               rb;
    logic [LINE_W-1:0]  line_cnt;
    logic [ADDR_W-1:0]  rd_x;
    logic               rd_valid;
    logic               overflow_err;
    logic               wr_en;
    logic               eol;
    logic               hs;
    logic               hs_eol;
    logic               accept;
    logic               ram_re;
    logic [ADDR_W-1:0]  ram_addr;
    always_comb begin
        wr_en    = bus.wr_we && full_cnt != 2'd2 && {1'b0, bus.wr_addr} < (ADDR_W + 1)'(X_SIZE);
        eol      = rd_x == ADDR_W'(X_SIZE - 1);
        hs       = state == R_STREAM && rd_valid && bus.rd_ready;
        hs_eol   = hs && eol;
        // a drain finishing in the same cycle frees a bank, so the line is taken even when full
        accept   = bus.wr_line_done && (full_cnt != 2'd2 || hs_eol);
        ram_re   = (state == R_IDLE && full_cnt != 2'd0) || (hs && !eol);
        ram_addr = state == R_IDLE ? '0 : rd_x + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wb][bus.wr_addr] <= bus.wr_depth;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= R_IDLE;
            full_cnt     <= '0;
            wb           <= 1'b0;
            rb           <= 1'b0;
            line_cnt     <= '0;
            rd_x         <= '0;
            rd_valid     <= 1'b0;
            ram_q        <= '0;
            overflow_err <= 1'b0;
        end else begin
            full_cnt <= full_cnt + {1'b0, accept} - {1'b0, hs_eol};
            if (accept) wb <= ~wb;
            if (bus.wr_line_done && !accept) overflow_err <= 1'b1;
            if (ram_re) ram_q <= mem[rb][ram_addr];
            case (state)
                R_IDLE: if (full_cnt != 2'd0) state <= R_FETCH;
                R_FETCH: begin
                    state    <= R_STREAM;
                    rd_valid <= 1'b1;
                    rd_x     <= '0;
                end
                R_STREAM: if (hs) begin
                    if (eol) begin
                        state    <= R_IDLE;
                        rd_valid <= 1'b0;
                        rd_x     <= '0;
                        rb       <= ~rb;
                        line_cnt <= line_cnt == LINE_W'(Y_SIZE - 1) ? '0 : line_cnt + 1'b1;
                    end else begin
                        rd_x <= rd_x + 1'b1;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end
    assign bus.wr_ready       = full_cnt != 2'd2;
    assign bus.rd_depth       = ram_q;
    assign bus.rd_valid       = rd_valid;
    assign bus.rd_x           = rd_x;
    assign bus.rd_sol         = rd_x == '0;
    assign bus.rd_eol         = eol;
    assign bus.rd_sof         = rd_x == '0 && line_cnt == '0;
    assign bus.lines_buffered = full_cnt;
    assign bus.overflow_err   = overflow_err;
endmodule

// File: tb/tb_depth_line_buffer.sv
// tb_depth_line_buffer: scoreboard bench for the ping-pong depth line buffer
module tb_depth_line_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    depth_line_buffer_if #(.ADDR_W(10), .DEPTH_W(10)) bus ();
    depth_line_buffer_if #(.ADDR_W(2), .DEPTH_W(10)) bus2 ();

    depth_line_buffer #(.X_SIZE(640), .Y_SIZE(480), .DEPTH_W(10), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    // short lines so a whole frame of 480 lines fits in a quick run
    depth_line_buffer #(.X_SIZE(4), .Y_SIZE(480), .DEPTH_W(10), .ADDR_W(2)) dut_frame (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    logic [22:0] exp_q[$];
    logic [4:0]  exp2_q[$];
    int          vectors = 0;
    int          errors = 0;
    int          hs = 0;
    int          exp_line = 0;
    bit          stalled = 1'b0;
    logic [20:0] held;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input int base);
        for (int a = 0; a < 640; a++) begin
            bus.wr_we = 1'b1;
            bus.wr_addr = 10'(a);
            bus.wr_depth = 10'(a + base);
            tick();
        end
        bus.wr_we = 1'b0;
    endtask

    task automatic push_line(input int base);
        for (int a = 0; a < 640; a++)
            exp_q.push_back({a == 0 && exp_line == 0, a == 639, a == 0, 10'(a), 10'(a + base)});
        exp_line = (exp_line + 1) % 480;
    endtask

    task automatic line_done();
        bus.wr_line_done = 1'b1;
        tick();
        bus.wr_line_done = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_x(input string name, input int x);
        int k = 0;
        while (!(bus.rd_valid && bus.rd_x == 10'(x)) && k < 3000) begin
            tick();
            k++;
        end
        check(name, int'(bus.rd_x), x);
    endtask

    initial forever begin
        @(negedge clk);
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check("stall_hold", {bus.rd_valid, bus.rd_x, bus.rd_depth}, held);
            if (bus.rd_valid && bus.rd_ready) begin
                hs++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_word: got x=%0d depth=%0d, expected no word", bus.rd_x, bus.rd_depth);
                end else begin
                    check("word", {bus.rd_sof, bus.rd_eol, bus.rd_sol, bus.rd_x, bus.rd_depth}, exp_q.pop_front());
                end
            end
            stalled = bus.rd_valid && !bus.rd_ready;
            held = {bus.rd_valid, bus.rd_x, bus.rd_depth};
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset && bus2.rd_valid && bus2.rd_ready) begin
            if (exp2_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_frame_word: got x=%0d, expected no word", bus2.rd_x);
            end else begin
                check("frame_markers", {bus2.rd_sof, bus2.rd_eol, bus2.rd_sol, bus2.rd_x}, exp2_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int h0;
        bus.wr_we = 1'b0; bus.wr_addr = '0; bus.wr_depth = '0; bus.wr_line_done = 1'b0; bus.rd_ready = 1'b0;
        bus2.wr_we = 1'b0; bus2.wr_addr = '0; bus2.wr_depth = '0; bus2.wr_line_done = 1'b0; bus2.rd_ready = 1'b1;
        repeat (3) tick();
        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_rd_x", bus.rd_x, 0);
        check("reset_rd_depth", bus.rd_depth, 0);
        check("reset_lines", bus.lines_buffered, 0);
        check("reset_wr_ready", bus.wr_ready, 1);
        check("reset_overflow", bus.overflow_err, 0);
        reset = 1'b0;
        // basic line, latency and back-to-back words
        write_line(0);
        bus.rd_ready = 1'b1;
        push_line(0);
        line_done();
        check("latency_c1", bus.rd_valid, 0);
        tick();
        check("latency_c2", bus.rd_valid, 0);
        tick();
        check("latency_c3", bus.rd_valid, 1);
        check("lines_during_drain", bus.lines_buffered, 1);
        repeat (640) tick();
        check("t1_valid_after", bus.rd_valid, 0);
        check("t1_pending", exp_q.size(), 0);
        // backpressure every other cycle
        write_line(100);
        push_line(100);
        h0 = hs;
        line_done();
        k = 0;
        while (exp_q.size() != 0 && k < 4000) begin
            bus.rd_ready = ~bus.rd_ready;
            tick();
            k++;
        end
        check("t2_pending", exp_q.size(), 0);
        check("t2_handshakes", hs - h0, 640);
        // both banks full, blocked writes, coincident line_done/eol, overflow
        bus.rd_ready = 1'b0;
        write_line(200);
        push_line(200);
        line_done();
        write_line(300);
        push_line(300);
        line_done();
        check("t3_wr_ready", bus.wr_ready, 0);
        check("t3_lines", bus.lines_buffered, 2);
        write_line(400);
        bus.rd_ready = 1'b1;
        wait_x("t4_reach_eol", 639);
        push_line(200);
        bus.wr_line_done = 1'b1;
        tick();
        bus.wr_line_done = 1'b0;
        check("t4_lines", bus.lines_buffered, 2);
        check("t4_overflow", bus.overflow_err, 0);
        bus.rd_ready = 1'b0;
        line_done();
        check("t3_overflow", bus.overflow_err, 1);
        check("t3_lines_after_ovf", bus.lines_buffered, 2);
        bus.rd_ready = 1'b1;
        wait_empty("t3_drain", 5000);
        check("t3_lines_drained", bus.lines_buffered, 0);
        check("t3_wr_ready_drained", bus.wr_ready, 1);
        // out-of-range write, then reset in mid-stream
        write_line(500);
        bus.wr_we = 1'b1;
        bus.wr_addr = 10'd700;
        bus.wr_depth = 10'h3ff;
        tick();
        bus.wr_we = 1'b0;
        push_line(500);
        line_done();
        wait_empty("t5_drain", 2000);
        write_line(600);
        push_line(600);
        line_done();
        wait_x("t5_reach_300", 300);
        reset = 1'b1;
        exp_q.delete();
        exp_line = 0;
        tick();
        check("t5_rst_valid", bus.rd_valid, 0);
        check("t5_rst_lines", bus.lines_buffered, 0);
        check("t5_rst_wr_ready", bus.wr_ready, 1);
        check("t5_rst_overflow", bus.overflow_err, 0);
        reset = 1'b0;
        tick();
        write_line(50);
        push_line(50);
        line_done();
        wait_empty("t5_post_reset", 2000);
        // a full frame plus two lines for sof wrap
        for (int l = 0; l < 482; l++) begin
            k = 0;
            while (!bus2.wr_ready && k < 50) begin
                tick();
                k++;
            end
            check("t6_wr_ready", bus2.wr_ready, 1);
            for (int x = 0; x < 4; x++)
                exp2_q.push_back({x == 0 && l % 480 == 0, x == 3, x == 0, 2'(x)});
            bus2.wr_line_done = 1'b1;
            tick();
            bus2.wr_line_done = 1'b0;
        end
        k = 0;
        while (exp2_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        check("t6_pending", exp2_q.size(), 0);
        check("t6_overflow", bus2.overflow_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
